// File: rtl/xor_write_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// xor_write_scheduler_pkg
// Shared constants, types and helpers for the XOR row-update write scheduler.
//   NUM_MUL      : update lanes (replicas), maximum grants per cycle
//   NUM_WR       : write requester ports
//   INDEX_WIDTH  : row index width
//   DATA_WIDTH   : write data width per port
//   lane_onehot(): lane number -> one-hot lane select
// ---------------------------------------------------------------------------
package xor_write_scheduler_pkg;

    localparam int NUM_MUL     = 4;
    localparam int NUM_WR      = 8;
    localparam int INDEX_WIDTH = 12;
    localparam int DATA_WIDTH  = 64;

    localparam int LANE_W  = (NUM_MUL > 1) ? $clog2(NUM_MUL) : 1;
    localparam int PTR_W   = (NUM_WR > 1) ? $clog2(NUM_WR) : 1;
    localparam int COUNT_W = $clog2(NUM_MUL + 1);

    typedef logic [INDEX_WIDTH-1:0] index_t;
    typedef logic [DATA_WIDTH-1:0]  data_t;
    typedef logic [LANE_W-1:0]      lane_t;
    typedef logic [PTR_W-1:0]       ptr_t;
    typedef logic [COUNT_W-1:0]     count_t;

    function automatic logic [NUM_MUL-1:0] lane_onehot(input lane_t lane);
        logic [NUM_MUL-1:0] oh;
        oh       = '0;
        oh[lane] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/xor_write_scheduler_if.sv
// ---------------------------------------------------------------------------
// xor_write_scheduler_if
// Request side and row-update-pipeline side bundle of the write scheduler.
//   wr_req_valid/ready/index/data : per-port write request handshake
//   hold_off                      : suppresses all grants while high
//   write_reg_0_valid/index       : registered grant valid and index per port
//   arbiter_result                : registered one-hot lane select per port
//   write_data_out                : registered data of granted ports
//   grant_count                   : registered number of grants this cycle
// master = requester/consumer side, slave = scheduler.
// ---------------------------------------------------------------------------
interface xor_write_scheduler_if;
    import xor_write_scheduler_pkg::*;

    logic [NUM_WR-1:0]             wr_req_valid;
    logic [NUM_WR-1:0]             wr_req_ready;
    logic [NUM_WR*INDEX_WIDTH-1:0] wr_req_index;
    logic [NUM_WR*DATA_WIDTH-1:0]  wr_req_data;
    logic                          hold_off;
    logic [NUM_WR-1:0]             write_reg_0_valid;
    logic [NUM_WR*INDEX_WIDTH-1:0] write_reg_0_index;
    logic [NUM_WR*NUM_MUL-1:0]     arbiter_result;
    logic [NUM_WR*DATA_WIDTH-1:0]  write_data_out;
    count_t                        grant_count;

    modport master (
        output wr_req_valid, wr_req_index, wr_req_data, hold_off,
        input  wr_req_ready, write_reg_0_valid, write_reg_0_index,
               arbiter_result, write_data_out, grant_count
    );

    modport slave (
        input  wr_req_valid, wr_req_index, wr_req_data, hold_off,
        output wr_req_ready, write_reg_0_valid, write_reg_0_index,
               arbiter_result, write_data_out, grant_count
    );

endinterface

// File: rtl/xor_write_scheduler_rr_lane_allocator.sv
// ---------------------------------------------------------------------------
// rr_lane_allocator
// Combinational round-robin scan over the holding slots. Starting at rr_ptr,
// each occupied slot whose index differs from all indices already granted
// this cycle takes the next free lane, until NUM_MUL lanes are used.
//   rr_ptr_i   : first port to scan
//   hv_i       : slot occupied flags
//   hidx_i     : slot indices
//   hold_off_i : blocks all grants
//   grant_o    : per-port grant this cycle
//   lane_o     : lane number of each granted port (0 for ungranted)
//   count_o    : number of grants
//   last_o     : last granted port in scan order
//   any_o      : at least one grant
// ---------------------------------------------------------------------------
module rr_lane_allocator
    import xor_write_scheduler_pkg::*;
(
    input  ptr_t              rr_ptr_i,
    input  logic [NUM_WR-1:0] hv_i,
    input  index_t            hidx_i [NUM_WR],
    input  logic              hold_off_i,
    output logic [NUM_WR-1:0] grant_o,
    output lane_t             lane_o [NUM_WR],
    output count_t            count_o,
    output ptr_t              last_o,
    output logic              any_o
);

    logic [NUM_WR-1:0] grant;
    int                cnt;
    int                scan;
    ptr_t              p;
    ptr_t              last;
    logic              clash;

    // NOTE: blocking assignments here are deliberate: the scan reads back
    // grant/cnt updated earlier in the same pass, which only works as
    // ordered combinational evaluation.
    always_comb begin
        grant = '0;
        cnt   = 0;
        scan  = 0;
        p     = '0;
        clash = 1'b0;
        last  = rr_ptr_i;
        for (int i = 0; i < NUM_WR; i++) begin
            lane_o[i] = '0;
        end
        for (int k = 0; k < NUM_WR; k++) begin
            scan = (int'(rr_ptr_i) + k) % NUM_WR;
            p    = ptr_t'(scan);
            if (!hold_off_i && (cnt < NUM_MUL) && hv_i[p]) begin
                // Two lanes writing the same row in one cycle would race in
                // the update pipeline; the later port waits instead.
                clash = 1'b0;
                for (int j = 0; j < NUM_WR; j++) begin
                    if (grant[j] && (hidx_i[j] == hidx_i[p])) begin
                        clash = 1'b1;
                    end
                end
                if (!clash) begin
                    grant[p]  = 1'b1;
                    lane_o[p] = lane_t'(cnt);
                    cnt       = cnt + 1;
                    last      = p;
                end
            end
        end
        grant_o = grant;
        count_o = count_t'(cnt);
        last_o  = last;
        any_o   = |grant;
    end

endmodule

// File: rtl/xor_write_scheduler.sv
// ---------------------------------------------------------------------------
// xor_write_scheduler
// Front-end controller for the row update datapath. Each requester port has a
// one-entry holding slot; occupied slots are granted onto the NUM_MUL replica
// lanes by rr_lane_allocator and the grants are registered toward the 3-stage
// row update pipeline.
//   clk   : clock
//   reset : asynchronous active-low reset
//   bus   : request handshake and registered grant outputs (slave side)
// ---------------------------------------------------------------------------
module xor_write_scheduler
    import xor_write_scheduler_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    xor_write_scheduler_if.slave bus
);

    // Holding slots
    logic [NUM_WR-1:0] hv_q, hv_d;
    index_t            hidx_q  [NUM_WR];
    index_t            hidx_d  [NUM_WR];
    data_t             hdata_q [NUM_WR];
    data_t             hdata_d [NUM_WR];
    ptr_t              rr_ptr_q, rr_ptr_d;

    // Allocator results
    logic [NUM_WR-1:0] grant_now;
    lane_t             lane [NUM_WR];
    count_t            grant_cnt;
    ptr_t              last_port;
    logic              any_grant;

    logic [NUM_WR-1:0] ready;
    logic [NUM_WR-1:0] accept;

    // Output registers
    logic [NUM_WR-1:0]             valid_q, valid_d;
    logic [NUM_WR*INDEX_WIDTH-1:0] index_q, index_d;
    logic [NUM_WR*NUM_MUL-1:0]     arb_q, arb_d;
    logic [NUM_WR*DATA_WIDTH-1:0]  data_q, data_d;
    count_t                        count_q, count_d;

    rr_lane_allocator u_alloc (
        .rr_ptr_i   (rr_ptr_q),
        .hv_i       (hv_q),
        .hidx_i     (hidx_q),
        .hold_off_i (bus.hold_off),
        .grant_o    (grant_now),
        .lane_o     (lane),
        .count_o    (grant_cnt),
        .last_o     (last_port),
        .any_o      (any_grant)
    );

    // A slot being granted this cycle frees up at the same edge, so it can
    // take a new request without a bubble.
    assign ready            = ~hv_q | grant_now;
    assign accept           = bus.wr_req_valid & ready;
    assign bus.wr_req_ready = ready;

    // NOTE: every output of this block is given a default before any
    // conditional assignment, so no path leaves a value held (no latch).
    always_comb begin
        hv_d     = accept | (hv_q & ~grant_now);
        rr_ptr_d = rr_ptr_q;
        valid_d  = grant_now;
        index_d  = '0;
        arb_d    = '0;
        data_d   = '0;
        count_d  = grant_cnt;
        for (int i = 0; i < NUM_WR; i++) begin
            hidx_d[i]  = hidx_q[i];
            hdata_d[i] = hdata_q[i];
            if (accept[i]) begin
                hidx_d[i]  = bus.wr_req_index[i*INDEX_WIDTH +: INDEX_WIDTH];
                hdata_d[i] = bus.wr_req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
            // Outputs take the old slot contents even when a new request
            // replaces the slot on the same edge.
            if (grant_now[i]) begin
                index_d[i*INDEX_WIDTH +: INDEX_WIDTH] = hidx_q[i];
                arb_d[i*NUM_MUL +: NUM_MUL]           = lane_onehot(lane[i]);
                data_d[i*DATA_WIDTH +: DATA_WIDTH]    = hdata_q[i];
            end
        end
        if (any_grant) begin
            rr_ptr_d = (last_port == ptr_t'(NUM_WR - 1)) ? '0 : last_port + ptr_t'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hv_q     <= '0;
            rr_ptr_q <= '0;
            valid_q  <= '0;
            index_q  <= '0;
            arb_q    <= '0;
            data_q   <= '0;
            count_q  <= '0;
        end else begin
            hv_q     <= hv_d;
            rr_ptr_q <= rr_ptr_d;
            valid_q  <= valid_d;
            index_q  <= index_d;
            arb_q    <= arb_d;
            data_q   <= data_d;
            count_q  <= count_d;
        end
    end

    // NOTE: slot payload is not reset; it is only ever observed while hv_q
    // marks the slot occupied, and hv_q itself is reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_WR; i++) begin
            hidx_q[i]  <= hidx_d[i];
            hdata_q[i] <= hdata_d[i];
        end
    end

    assign bus.write_reg_0_valid = valid_q;
    assign bus.write_reg_0_index = index_q;
    assign bus.arbiter_result    = arb_q;
    assign bus.write_data_out    = data_q;
    assign bus.grant_count       = count_q;

endmodule

// File: tb/tb_xor_write_scheduler.sv
// ---------------------------------------------------------------------------
// tb_xor_write_scheduler
// Directed vector table, hand-written multi-cycle sequences and randomized
// traffic against a queue-based reference of the scheduling rules.
// ---------------------------------------------------------------------------
module tb_xor_write_scheduler;
    import xor_write_scheduler_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    xor_write_scheduler_if bus ();

    xor_write_scheduler dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    bit     m_hv   [NUM_WR];
    index_t m_idx  [NUM_WR];
    data_t  m_data [NUM_WR];
    int     m_ptr;
    int     gnt_q[$];   // granted ports in lane order

    logic [NUM_WR-1:0]             e_valid;
    logic [NUM_WR*INDEX_WIDTH-1:0] e_index;
    logic [NUM_WR*NUM_MUL-1:0]     e_arb;
    logic [NUM_WR*DATA_WIDTH-1:0]  e_data;
    int                            e_cnt;

    function automatic void model_reset();
        for (int i = 0; i < NUM_WR; i++) m_hv[i] = 1'b0;
        m_ptr   = 0;
        e_valid = '0;
        e_index = '0;
        e_arb   = '0;
        e_data  = '0;
        e_cnt   = 0;
    endfunction

    function automatic void model_pick();
        index_t used[$];
        gnt_q.delete();
        if (bus.hold_off) return;
        for (int k = 0; k < NUM_WR; k++) begin
            int p;
            bit dup;
            p   = (m_ptr + k) % NUM_WR;
            dup = 1'b0;
            if (m_hv[p] && gnt_q.size() < NUM_MUL) begin
                foreach (used[u]) if (used[u] == m_idx[p]) dup = 1'b1;
                if (!dup) begin
                    gnt_q.push_back(p);
                    used.push_back(m_idx[p]);
                end
            end
        end
    endfunction

    // One clock: check ready before the edge, advance model, check outputs.
    task automatic step();
        logic [NUM_WR-1:0] gmask, rdy, acc;
        int p;
        model_pick();
        gmask = '0;
        foreach (gnt_q[g]) gmask[gnt_q[g]] = 1'b1;
        for (int i = 0; i < NUM_WR; i++) rdy[i] = !m_hv[i] || gmask[i];
        #1;
        check("ready", bus.wr_req_ready, rdy);
        acc = bus.wr_req_valid & rdy;
        @(posedge clk);
        e_valid = gmask;
        e_index = '0;
        e_arb   = '0;
        e_data  = '0;
        e_cnt   = gnt_q.size();
        foreach (gnt_q[g]) begin
            p = gnt_q[g];
            e_index[p*INDEX_WIDTH +: INDEX_WIDTH] = m_idx[p];
            e_arb[p*NUM_MUL + g]                  = 1'b1;
            e_data[p*DATA_WIDTH +: DATA_WIDTH]    = m_data[p];
        end
        if (gnt_q.size() > 0) m_ptr = (gnt_q[gnt_q.size()-1] + 1) % NUM_WR;
        for (int i = 0; i < NUM_WR; i++) begin
            if (acc[i]) begin
                m_hv[i]   = 1'b1;
                m_idx[i]  = bus.wr_req_index[i*INDEX_WIDTH +: INDEX_WIDTH];
                m_data[i] = bus.wr_req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end else if (gmask[i]) begin
                m_hv[i] = 1'b0;
            end
        end
        @(negedge clk);
        check("out_valid", bus.write_reg_0_valid, e_valid);
        check("out_index", bus.write_reg_0_index, e_index);
        check("out_arb",   bus.arbiter_result,    e_arb);
        check("out_data",  bus.write_data_out,    e_data);
        check("out_count", bus.grant_count,       e_cnt);
    endtask

    // Default indices 0x0A2+i (port 3 -> 0x0A5); ports in dup share 0x010.
    task automatic drive(input logic [NUM_WR-1:0] valid, input logic hold,
                         input logic [NUM_WR-1:0] dup, input data_t base);
        bus.wr_req_valid = valid;
        bus.hold_off     = hold;
        for (int i = 0; i < NUM_WR; i++) begin
            bus.wr_req_index[i*INDEX_WIDTH +: INDEX_WIDTH] = dup[i] ? 12'h010 : index_t'(12'h0A2 + i);
            bus.wr_req_data[i*DATA_WIDTH +: DATA_WIDTH]    = base + data_t'(i);
        end
    endtask

    typedef struct {
        logic [NUM_WR-1:0]         valid;
        logic                      hold;
        logic [NUM_WR-1:0]         dup;
        logic [NUM_WR-1:0]         exp_valid;
        int                        exp_cnt;
        logic [NUM_WR*NUM_MUL-1:0] exp_arb;
    } vec_t;

    localparam int NV = 10;
    vec_t vec [NV];

    initial begin
        data_t d_old, d_new;

        vec[0] = '{8'h08, 1'b0, 8'h00, 8'h00, 0, 32'h0000_0000}; // port 3 request
        vec[1] = '{8'h00, 1'b0, 8'h00, 8'h08, 1, 32'h0000_1000}; // port 3 lane 0
        vec[2] = '{8'h06, 1'b0, 8'h06, 8'h00, 0, 32'h0000_0000}; // ports 1,2 same index
        vec[3] = '{8'h00, 1'b0, 8'h00, 8'h02, 1, 32'h0000_0010}; // port 1 wins
        vec[4] = '{8'h00, 1'b0, 8'h00, 8'h04, 1, 32'h0000_0100}; // port 2 retried
        vec[5] = '{8'h1F, 1'b1, 8'h00, 8'h00, 0, 32'h0000_0000}; // hold: accept 0-4
        vec[6] = '{8'h00, 1'b1, 8'h00, 8'h00, 0, 32'h0000_0000};
        vec[7] = '{8'h00, 1'b1, 8'h00, 8'h00, 0, 32'h0000_0000};
        vec[8] = '{8'h00, 1'b0, 8'h00, 8'h1B, 4, 32'h0002_1084}; // ptr 3: 3,4,0,1
        vec[9] = '{8'h00, 1'b0, 8'h00, 8'h04, 1, 32'h0000_0100}; // port 2 last

        drive('0, 1'b0, '0, '0);
        model_reset();
        #2 reset = 1'b0;
        #1;
        check("reset_valid", bus.write_reg_0_valid, '0);
        check("reset_count", bus.grant_count, '0);
        check("reset_arb",   bus.arbiter_result, '0);
        check("reset_ready", bus.wr_req_ready, {NUM_WR{1'b1}});
        @(negedge clk);
        reset = 1'b1;

        // ---------------- directed table ----------------
        for (int t = 0; t < NV; t++) begin
            drive(vec[t].valid, vec[t].hold, vec[t].dup, 64'h1231);
            step();
            check($sformatf("vec%0d_valid", t), bus.write_reg_0_valid, vec[t].exp_valid);
            check($sformatf("vec%0d_count", t), bus.grant_count, vec[t].exp_cnt);
            check($sformatf("vec%0d_arb", t),   bus.arbiter_result, vec[t].exp_arb);
            if (t == 1) begin
                check("single_index", bus.write_reg_0_index[3*INDEX_WIDTH +: INDEX_WIDTH], 12'h0A5);
                check("single_data",  bus.write_data_out[3*DATA_WIDTH +: DATA_WIDTH], 64'h1234);
            end
        end

        // ---------------- same-edge grant and accept on port 0 ----------------
        d_old = 64'hAAAA_0000_0000_0001;
        d_new = 64'hBBBB_0000_0000_0002;
        drive(8'h01, 1'b0, '0, d_old);
        step();
        drive(8'h01, 1'b0, '0, d_new);
        step();
        check("same_edge_old", bus.write_data_out[0 +: DATA_WIDTH], d_old);
        drive('0, 1'b0, '0, '0);
        step();
        check("same_edge_new", bus.write_data_out[0 +: DATA_WIDTH], d_new);
        step();
        check("same_edge_nodup", bus.write_reg_0_valid, '0);

        // ---------------- reset mid-stream ----------------
        drive({NUM_WR{1'b1}}, 1'b0, '0, 64'h5000);
        step();
        step();
        #2 reset = 1'b0;
        #1;
        check("midreset_valid", bus.write_reg_0_valid, '0);
        check("midreset_data",  bus.write_data_out, '0);
        check("midreset_count", bus.grant_count, '0);
        check("midreset_ready", bus.wr_req_ready, {NUM_WR{1'b1}});
        model_reset();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        drive('0, 1'b0, '0, '0);
        step();
        check("post_reset_stale", bus.write_reg_0_valid, '0);

        // ---------------- all ports continuously valid ----------------
        for (int s = 0; s < 6; s++) begin
            drive({NUM_WR{1'b1}}, 1'b0, '0, data_t'(s) << 16);
            step();
            if (s == 0) begin
                check("full_first", bus.write_reg_0_valid, '0);
            end else begin
                check($sformatf("full%0d_valid", s), bus.write_reg_0_valid,
                      (s % 2 == 1) ? 8'h0F : 8'hF0);
                check($sformatf("full%0d_count", s), bus.grant_count, 4);
            end
        end
        drive('0, 1'b0, '0, '0);
        step();
        step();

        // ---------------- randomized traffic ----------------
        for (int r = 0; r < 400; r++) begin
            bus.wr_req_valid = NUM_WR'($urandom);
            bus.hold_off     = ($urandom_range(0, 4) == 0);
            for (int i = 0; i < NUM_WR; i++) begin
                bus.wr_req_index[i*INDEX_WIDTH +: INDEX_WIDTH] = index_t'($urandom_range(0, 5));
                bus.wr_req_data[i*DATA_WIDTH +: DATA_WIDTH]    = {$urandom, $urandom};
            end
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/xor_write_scheduler.md
Name: xor_write_scheduler

Overview:
- Front-end controller for the row update datapath.
- Accepts up to NUM_WR independent write requests (index + data) through valid/ready handshakes.
- Grants at most NUM_MUL of them per cycle onto the NUM_MUL replica update lanes, using round-robin priority and same-index conflict suppression.
- Drives the per-port valid, index, one-hot lane-select (arbiter_result) and data bundles consumed by the 3-stage row update pipeline.

Parameters:
- NUM_MUL, 4: number of update lanes (replicas); maximum grants per cycle.
- NUM_WR, 8: number of write requester ports.
- INDEX_WIDTH, 12: row index width.
- DATA_WIDTH, 64: write data width per port.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- wr_req_valid  in  NUM_WR  per-port request valid.
- wr_req_ready  out  NUM_WR  per-port request ready.
- wr_req_index  in  NUM_WR*INDEX_WIDTH  per-port target index; port i at [i*INDEX_WIDTH +: INDEX_WIDTH].
- wr_req_data  in  NUM_WR*DATA_WIDTH  per-port write data.
- hold_off  in  1  when high, suppresses all grants (read-priority window).
- write_reg_0_valid  out  NUM_WR  registered grant valid per port.
- write_reg_0_index  out  NUM_WR*INDEX_WIDTH  registered index of granted ports.
- arbiter_result  out  NUM_WR*NUM_MUL  registered one-hot lane select; port i at [i*NUM_MUL +: NUM_MUL].
- write_data_out  out  NUM_WR*DATA_WIDTH  registered data of granted ports.
- grant_count  out  clog2(NUM_MUL+1)  registered number of grants issued.

Behaviour:
- Reset (reset==0, async):
  - All outputs 0.
  - All holding slots empty.
  - rr_ptr = 0.
  - wr_req_ready is combinational, so it reads all-ones while in reset.
- Holding slots:
  - Each port has a one-entry holding slot (hv[i], hidx[i], hdata[i]).
  - wr_req_ready[i] = ~hv[i] | grant_now[i].
  - A request is accepted on a rising edge when valid&ready. The slot loads; hv stays or becomes 1.
  - A granted slot with no new accept clears hv.
- Grant computation (combinational on slot contents only, never on incoming requests):
  - Scan ports in order rr_ptr, rr_ptr+1, ... mod NUM_WR.
  - Candidate = hv[i]==1 and hidx[i] differs from every index already granted this cycle.
  - The k-th granted candidate (k = 0..NUM_MUL-1) gets lane k.
  - The scan stops once NUM_MUL grants are made.
  - A conflicting port stays held and is not granted this cycle; it is retried in a later cycle.
  - hold_off=1: grant_now = 0. Slots still accept while empty.
- Outputs, registered at the edge after the grant decision:
  - write_reg_0_valid = grant_now.
  - arbiter_result[i] = onehot(lane) for granted ports, 0 otherwise.
  - write_reg_0_index and write_data_out carry slot contents for granted ports and 0 for ungranted ports.
  - Latency: request accepted at edge E0; earliest output at edge E1.
- Pointer update:
  - If any grant is made, rr_ptr = (last granted port + 1) mod NUM_WR.
  - Otherwise rr_ptr is unchanged.
  - Guarantees starvation freedom: a held port is granted within ceil(NUM_WR/NUM_MUL)+1 non-hold_off cycles, barring repeated same-index conflicts.
- Invariants:
  - At most one port per lane.
  - Popcount(write_reg_0_valid) == grant_count ≤ NUM_MUL.
  - No two valid outputs in the same cycle share an index.
- Boundary conditions:
  - All NUM_WR ports full: exactly NUM_MUL grants per cycle, rotating.
  - Grant and new accept on the same port and edge: the new request replaces the slot, and the old request goes out on the outputs.
  - Reset mid-operation: held requests are discarded, not replayed.

Decomposition:
- Shared package: lane one-hot encode function; clog2 constant for grant_count width.
- One sub-module, rr_lane_allocator: the combinational scan (pointer, hv, indices) producing grant_now and per-port lane numbers.
- The top level holds slots, pointer and output registers.

Test Plan:
- Single request: port 3 index 0x0A5, data 0x1234 at E0 -> at E1 write_reg_0_valid=0x08, arbiter_result lane0 for port3, index 0x0A5, grant_count=1; rr_ptr=4.
- All 8 ports valid continuously, distinct indices -> cycle A grants ports 0-3 on lanes 0-3; cycle B grants ports 4-7; each port ready every other cycle; grant_count=4 every cycle.
- Ports 1 and 2 both index 0x010, rr_ptr=0 -> port1 granted lane0; port2 held and granted next cycle on lane0; never both in the same cycle.
- hold_off high 3 cycles with 5 held ports -> no valid outputs, ready=0 on held ports; on release, 4 grants then 1 grant.
- Reset asserted low mid-stream with held ports -> all outputs 0 immediately (async); after release no stale grants appear, and new requests start at rr_ptr=0.
- Same-edge grant and accept on port 0 -> old data emitted; new data emitted next cycle; no loss or duplication, checked by scoreboard.
